bit_serial_adder: RTL

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder_pkg.sv | 15 +
 rtl/fulladder.sv | 13 +
 rtl/bit_serial_adder.sv | 97 +++++++++
 3 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and sizing helpers.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must reach WIDTH without wrapping.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder shared by the serial datapaths.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial add/subtract through one full adder; one result per WIDTH+1 cycles.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             carryout_q;
    logic             overflow_q;
    logic             fa_s;
    logic             fa_c;

    fulladder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // Status flags trail the state by one cycle so busy spans exactly the bit cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            busy_q <= (state_q == ST_RUN);
            done_q <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        carryout_q <= fa_c;
                        overflow_q <= carry_q ^ fa_c;
                        state_q    <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = ~|sum_q;

endmodule
